// File: rtl/microseq_pipe_ctrl.sv
// rtl/microseq_pipe_ctrl.sv - micro-PC sequencer feeding a three-stage C/T pipeline
module microseq_pipe_ctrl (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [4:0] start_addr,
  input  logic       stall,
  input  logic       flush,
  output logic [4:0] rom_addr,
  input  logic [5:0] rom_C,
  input  logic [6:0] rom_T,
  output logic [5:0] C3,
  output logic [6:0] T3,
  output logic       v3,
  output logic [5:0] C4,
  output logic [6:0] T4,
  output logic       v4,
  output logic [5:0] C5,
  output logic [6:0] T5,
  output logic       v5,
  output logic       busy,
  output logic       done,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t     state, state_nxt;
  logic [4:0] upc;
  logic       advance;
  logic       drained;
  logic       last;
  logic       accept;

  assign advance  = !stall;
  assign drained  = !v3 && !v4 && !v5;
  assign last     = rom_T[6];
  assign accept   = (state == IDLE) && start;
  assign busy     = (state != IDLE);
  assign rom_addr = upc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (advance && last) state_nxt = DRAIN;
      DRAIN:   if (drained) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      upc      <= 5'd0;
      C3       <= 6'd0;
      T3       <= 7'd0;
      v3       <= 1'b0;
      C4       <= 6'd0;
      T4       <= 7'd0;
      v4       <= 1'b0;
      C5       <= 6'd0;
      T5       <= 7'd0;
      v5       <= 1'b0;
      done     <= 1'b0;
      op_count <= 8'd0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        // C/T payloads are left alone; only the valid bits matter downstream
        v3  <= 1'b0;
        v4  <= 1'b0;
        v5  <= 1'b0;
        upc <= 5'd0;
      end else begin
        if (accept)
          upc <= start_addr;
        else if (state == RUN && advance && !last)
          upc <= upc + 5'd1;

        if (state == DRAIN && drained)
          done <= 1'b1;

        if (advance) begin
          if (state == RUN) begin
            C3 <= rom_C;
            T3 <= rom_T;
            v3 <= 1'b1;
          end else begin
            v3 <= 1'b0;
          end
          C4 <= C3;
          T4 <= T3;
          v4 <= v3;
          C5 <= C4;
          T5 <= T4;
          v5 <= v4;
        end

        if (accept)
          op_count <= 8'd0;
        else if (advance && v5 && op_count != 8'hff)
          op_count <= op_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_microseq_pipe_ctrl.sv
// tb/tb_microseq_pipe_ctrl.sv - scoreboard bench for microseq_pipe_ctrl
module tb_microseq_pipe_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] start_addr = 5'd0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic [4:0] rom_addr;
  logic [5:0] rom_C;
  logic [6:0] rom_T;
  logic [5:0] C3, C4, C5;
  logic [6:0] T3, T4, T5;
  logic       v3, v4, v5;
  logic       busy, done;
  logic [7:0] op_count;

  logic [5:0]  rom_c [32];
  logic [6:0]  rom_t [32];
  logic [12:0] exp_q [$];
  logic [12:0] item;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int exp_len = 0;

  always #5 clock = ~clock;

  assign rom_C = rom_c[rom_addr];
  assign rom_T = rom_t[rom_addr];

  microseq_pipe_ctrl dut (
    .clock(clock), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .stall(stall), .flush(flush), .rom_addr(rom_addr), .rom_C(rom_C), .rom_T(rom_T),
    .C3(C3), .T3(T3), .v3(v3), .C4(C4), .T4(T4), .v4(v4),
    .C5(C5), .T5(T5), .v5(v5), .busy(busy), .done(done), .op_count(op_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: every retirement pops the scoreboard, every done checks the totals
  always @(negedge clock) begin
    if (reset_n) begin
      if (v5 && !stall && !flush) begin
        if (exp_q.size() == 0) begin
          chk("retire_unexpected", 1, 0);
        end else begin
          item = exp_q.pop_front();
          chk("retire_C5", C5, item[12:7]);
          chk("retire_T5", T5, item[6:0]);
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_op_count", op_count, exp_len);
        chk("done_busy", busy, 0);
        chk("done_queue_empty", exp_q.size(), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: walk the ROM from the start address until the LAST flag
  task automatic load_prog(input logic [4:0] a);
    logic [4:0] p;
    int n;
    p = a;
    n = 0;
    while (n < 64) begin
      exp_q.push_back({rom_c[p], rom_t[p]});
      n++;
      if (rom_t[p][6]) break;
      p = p + 5'd1;
    end
    exp_len = (n > 255) ? 255 : n;
  endtask

  task automatic issue_start(input logic [4:0] a);
    load_prog(a);
    start_addr = a;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int stall_pct, input string name);
    int base;
    int k;
    base = done_cnt;
    k = 0;
    while (done_cnt == base && k < 400) begin
      stall = ($urandom_range(0, 99) < stall_pct);
      tick();
      k++;
    end
    stall = 1'b0;
    if (done_cnt == base) chk({name, "_timeout"}, 0, 1);
    repeat (3) tick();
    chk({name, "_done_once"}, done_cnt, base + 1);
  endtask

  task automatic fixed_rom();
    for (int i = 0; i < 32; i++) begin
      rom_c[i] = 6'(i * 3 + 1);
      rom_t[i] = {1'b0, 6'(i ^ 42)};
    end
    rom_t[6][6] = 1'b1;
    rom_t[1][6] = 1'b1;
  endtask

  task automatic random_rom();
    for (int i = 0; i < 32; i++) begin
      rom_c[i] = 6'($urandom);
      rom_t[i] = {($urandom_range(0, 5) == 0), 6'($urandom)};
    end
    rom_t[$urandom_range(0, 31)][6] = 1'b1;
  endtask

  initial begin
    int n;
    logic [4:0] s_addr;
    logic [5:0] s_c3;
    logic       s_v3, s_v4, s_v5;
    int prev_op;
    int base;

    fixed_rom();
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_v", {v3, v4, v5}, 0);
    chk("rst_ct", {C3, C4, C5, T3, T4, T5}, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_done_opc", {done, op_count}, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Basic run: fetch order 4,5,6 and done seven cycles after acceptance
    issue_start(5'd4);
    chk("basic_addr0", rom_addr, 4);
    n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
      if (n == 1) chk("basic_addr1", rom_addr, 5);
      if (n == 2) chk("basic_addr2", rom_addr, 6);
    end
    chk("basic_done_latency", n, 7);
    repeat (3) tick();

    // Wrap-around 30,31,0,1
    issue_start(5'd30);
    chk("wrap_addr0", rom_addr, 30);
    tick(); chk("wrap_addr1", rom_addr, 31);
    tick(); chk("wrap_addr2", rom_addr, 0);
    tick(); chk("wrap_addr3", rom_addr, 1);
    wait_done(0, "wrap");

    // Two-cycle stall one cycle after start
    issue_start(5'd4);
    tick();
    stall = 1'b1;
    s_addr = rom_addr; s_c3 = C3; s_v3 = v3; s_v4 = v4; s_v5 = v5;
    repeat (2) begin
      tick();
      chk("stall_upc", rom_addr, s_addr);
      chk("stall_c3", C3, s_c3);
      chk("stall_v", {v3, v4, v5}, {s_v3, s_v4, s_v5});
    end
    stall = 1'b0;
    n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    chk("stall_done_latency", n, 6);
    repeat (3) tick();

    // Flush with v3=v4=1 and a simultaneous start
    issue_start(5'd4);
    tick();
    tick();
    chk("flush_pre_v", {v3, v4}, 3);
    prev_op = op_count;
    base = done_cnt;
    flush = 1'b1;
    start = 1'b1;
    start_addr = 5'd20;
    tick();
    flush = 1'b0;
    start = 1'b0;
    exp_q.delete();
    chk("flush_v", {v3, v4, v5}, 0);
    chk("flush_busy", busy, 0);
    chk("flush_upc", rom_addr, 0);
    chk("flush_opc", op_count, prev_op);
    repeat (5) tick();
    chk("flush_no_start", busy, 0);
    chk("flush_no_done", done_cnt, base);

    // Start while busy is ignored
    issue_start(5'd4);
    tick();
    start = 1'b1;
    start_addr = 5'd20;
    tick();
    start = 1'b0;
    chk("busy_start_upc", rom_addr, 6);
    wait_done(0, "busy_start");

    // Reset mid-DRAIN with v4=1
    issue_start(5'd4);
    n = 0;
    while (!(busy && !v3 && v4) && n < 20) begin
      tick();
      n++;
    end
    chk("rstd_reached", {busy, v3, v4}, 3'b101);
    base = done_cnt;
    reset_n = 1'b0;
    #1;
    chk("rstd_busy", busy, 0);
    chk("rstd_v", {v3, v4, v5}, 0);
    chk("rstd_ct", {C3, C4, C5, T3, T4, T5}, 0);
    chk("rstd_upc_opc", {rom_addr, op_count, done}, 0);
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("rstd_idle", busy, 0);
    chk("rstd_no_done", done_cnt, base);
    issue_start(5'd4);
    wait_done(0, "post_reset");

    // Randomized ROM contents, start addresses and stalls
    for (int r = 0; r < 20; r++) begin
      random_rom();
      issue_start(5'($urandom));
      wait_done(25, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/microseq_pipe_ctrl.md
MICROSEQ_PIPE_CTRL -- requirements
Module: microseq_pipe_ctrl

Interface
REQ-001 The block SHALL have the following parameter: none; widths are fixed at C=6 bits, T=7 bits, micro-PC=5 bits.
REQ-002 The block SHALL use a single clock and an asynchronous, active-low reset.
REQ-003 The ports SHALL be as follows:
- clock  in  1  rising-edge clock for all state.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  begin a microprogram; sampled only in IDLE.
- start_addr  in  5  first micro-PC of the program.
- stall  in  1  hold all pipeline stages and the micro-PC this cycle.
- flush  in  1  synchronous abort of the program.
- rom_addr  out  5  micro-PC driven to the asynchronous microcode ROM (equals upc).
- rom_C  in  6  ROM control field at rom_addr.
- rom_T  in  7  ROM T field at rom_addr; bit 6 = LAST flag.
- C3/T3/v3, C4/T4/v4, C5/T5/v5  out  6/7/1 each  stage 3/4/5 registers and valid bits.
- busy  out  1  high when the state is not IDLE.
- done  out  1  one-cycle pulse after the pipeline drains normally.
- op_count  out  8  microinstructions retired from stage 5.

Function
REQ-004 The block SHALL implement three states: IDLE, RUN and DRAIN.
REQ-005 advance SHALL equal !stall; while advance=0, the upc, all C/T/v stage registers and the state SHALL hold.
REQ-006 In IDLE with start=1, the block SHALL load upc<=start_addr, clear op_count to 0 and enter RUN, regardless of stall.
- start SHALL be ignored in RUN and DRAIN.
REQ-007 In RUN with advance=1:
- C3<=rom_C, T3<=rom_T, v3<=1.
- If rom_T[6]=0: upc<=upc+1, wrapping from 31 to 0.
- If rom_T[6]=1: upc SHALL hold and the state SHALL become DRAIN.
REQ-008 In IDLE and DRAIN with advance=1, v3<=0; C3/T3 SHALL hold.
REQ-009 On every advance=1 cycle, stage 4 SHALL load the stage 3 values and stage 5 SHALL load the stage 4 values (C, T and v).
- This applies in all states, so the pipeline always shifts on advance.
REQ-010 In DRAIN, when v3=v4=v5=0, the state SHALL become IDLE and done SHALL be 1 for exactly the next cycle.
- This transition SHALL be independent of stall.
REQ-011 op_count SHALL increment when v5=1 and advance=1, saturating at 255.
REQ-012 flush=1 SHALL take priority over start, stall and all transitions:
- v3, v4 and v5 are cleared; upc<=0; state<=IDLE.
- done SHALL stay 0; op_count SHALL hold.
- C/T registers SHALL hold.
REQ-013 busy SHALL be combinational: busy=(state!=IDLE).
REQ-014 rom_addr SHALL equal upc combinationally.
REQ-015 C5/T5 SHALL only be meaningful while v5=1.

Reset
REQ-016 reset_n=0 SHALL asynchronously force the following, with no stage valid while reset is asserted:
- state=IDLE.
- upc=0.
- C3..C5=0, T3..T5=0, v3..v5=0.
- done=0, op_count=0.
REQ-017 Reset asserted mid-RUN or mid-DRAIN SHALL abort without a done pulse.
- After release, the block SHALL wait in IDLE for start.

Verification
REQ-018 Basic run: ROM has LAST at address 6; start_addr=4; stall=0.
- rom_addr sequence is 4, 5, 6.
- v5 is high for 3 consecutive cycles with C5 equal to ROM[4..6].
- done pulses once; op_count=3; busy falls on the done cycle.
REQ-019 Wrap-around: start_addr=30; LAST at address 1.
- Fetch order is 30, 31, 0, 1.
- Final result: op_count=4 and done=1 once.
REQ-020 Stall: stall=1 for 2 cycles, one cycle after start, with the program at addresses 4..6.
- upc, C3..C5 and v3..v5 are frozen for those 2 cycles.
- Retirement order is unchanged; op_count=3; done is delayed by 2 cycles.
REQ-021 Flush: assert flush with v3=v4=1, together with start=1.
- Next cycle: v3=v4=v5=0, state IDLE, upc=0, done never pulses, start not accepted.
REQ-022 Start while busy: pulse start with start_addr=20 during RUN.
- Ignored; upc continues the current program.
REQ-023 Reset mid-DRAIN: drop reset_n with v4=1.
- Immediately all outputs are 0 and busy=0.
- After release, start_addr=4 runs normally, as in REQ-018.
